// File: rtl/xd_event_scheduler.sv
// ---------------------------------------------------------------------------
// xd_event_scheduler
//
// Source-domain controller that shares one toggle-based pulse-crossing
// channel among N_REQ event requesters. Single-cycle requests are latched
// into pend, granted round-robin, and each grant produces one flag_src pulse
// together with a stable requester id. After every launch the block holds
// off for GAP cycles so the destination synchroniser never merges toggles
// and always samples a settled id.
//
// Ports:
//   clk       in   1      source-domain clock
//   rst       in   1      asynchronous active-high reset
//   en        in   1      launch enable (requests still latch while low)
//   req       in   N_REQ  per-requester single-cycle event pulses
//   clr_ovr   in   1      clears all overrun bits
//   flag_src  out  1      single-cycle launch pulse to the crossing channel
//   id        out  ID_W   index of the last launched requester (held)
//   pend      out  N_REQ  latched-but-unsent requests
//   ovr       out  N_REQ  sticky overrun flags
//   busy      out  1      any pend bit set or holdoff in progress
// ---------------------------------------------------------------------------
module xd_event_scheduler #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int GAP   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             clr_ovr,
    output logic             flag_src,
    output logic [ID_W-1:0]  id,
    output logic [N_REQ-1:0] pend,
    output logic [N_REQ-1:0] ovr,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int              CNT_W      = 8;
    localparam logic [CNT_W-1:0] GAP_M1    = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [N_REQ-1:0] MASK_ONE  = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(N_REQ - 1);

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [ID_W-1:0]    last_r, last_nxt_s;
    logic [ID_W-1:0]    id_r, id_nxt_s;
    logic               flag_r, flag_nxt_s;
    logic [N_REQ-1:0]   pend_r, pend_nxt_s;
    logic [N_REQ-1:0]   ovr_r, ovr_nxt_s;
    logic               busy_r, busy_nxt_s;

    logic               grant_valid_s;
    logic [ID_W-1:0]    grant_idx_s;
    logic [N_REQ-1:0]   grant_mask_s;

    // Round-robin search: first set pend bit starting just after the last grant.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!grant_valid_s && pend_r[(int'(last_r) + k) % N_REQ]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = ID_W'((int'(last_r) + k) % N_REQ);
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // Launch/holdoff FSM next-state and registered-output next values.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        last_nxt_s   = last_r;
        id_nxt_s     = id_r;
        flag_nxt_s   = 1'b0;
        grant_mask_s = '0;
        case (state_r)
            IDLE: begin
                if (en && grant_valid_s) begin
                    grant_mask_s = MASK_ONE << grant_idx_s;
                    flag_nxt_s   = 1'b1;
                    id_nxt_s     = grant_idx_s;
                    last_nxt_s   = grant_idx_s;
                    cnt_nxt_s    = GAP_M1;
                    state_nxt_s  = LAUNCH;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            LAUNCH: begin
                cnt_nxt_s = cnt_r - CNT_ONE;
                // With GAP=2 the holdoff already expires at the end of the pulse.
                if (cnt_r <= CNT_ONE) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            HOLD: begin
                if (cnt_r <= CNT_ONE) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = IDLE;
                end else begin
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                cnt_nxt_s   = '0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Pending / overrun bookkeeping; a request on its own grant edge re-arms pend.
    always_comb begin
        pend_nxt_s = (pend_r & ~grant_mask_s) | req;
        if (clr_ovr) begin
            ovr_nxt_s = req & pend_r & ~grant_mask_s;
        end else begin
            ovr_nxt_s = ovr_r | (req & pend_r & ~grant_mask_s);
        end
        busy_nxt_s = (|pend_nxt_s) || (state_nxt_s != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            last_r  <= LAST_INIT;
            id_r    <= '0;
            flag_r  <= 1'b0;
            pend_r  <= '0;
            ovr_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            last_r  <= last_nxt_s;
            id_r    <= id_nxt_s;
            flag_r  <= flag_nxt_s;
            pend_r  <= pend_nxt_s;
            ovr_r   <= ovr_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    assign flag_src = flag_r;
    assign id       = id_r;
    assign pend     = pend_r;
    assign ovr      = ovr_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_xd_event_scheduler.sv
// ---------------------------------------------------------------------------
// tb_xd_event_scheduler
//
// Self-checking bench for xd_event_scheduler (N_REQ=4, ID_W=2, GAP=8).
// A table of per-cycle {inputs, expected outputs} covers reset, single-event
// latency and the four-way burst with GAP spacing; hand-written sequences
// cover round-robin order, overrun, same-edge re-request and async reset.
// ---------------------------------------------------------------------------
module tb_xd_event_scheduler;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int GAP   = 8;

    logic             clk;
    logic             rst;
    logic             en;
    logic [N_REQ-1:0] req;
    logic             clr_ovr;
    logic             flag_src;
    logic [ID_W-1:0]  id;
    logic [N_REQ-1:0] pend;
    logic [N_REQ-1:0] ovr;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    xd_event_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W), .GAP(GAP)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .clr_ovr  (clr_ovr),
        .flag_src (flag_src),
        .id       (id),
        .pend     (pend),
        .ovr      (ovr),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] req;
        logic       clr;
        logic       e_flag;
        logic [1:0] e_id;
        logic [3:0] e_pend;
        logic [3:0] e_ovr;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic e, input logic [3:0] q, input logic c,
                       input logic f, input logic [1:0] i, input logic [3:0] p,
                       input logic [3:0] o, input logic b);
        vec_t v;
        v.rst = r; v.en = e; v.req = q; v.clr = c;
        v.e_flag = f; v.e_id = i; v.e_pend = p; v.e_ovr = o; v.e_busy = b;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic f, input logic [1:0] i,
                           input logic [3:0] p, input logic [3:0] o, input logic b);
        n_vec++;
        if ({flag_src, id, pend, ovr, busy} !== {f, i, p, o, b}) begin
            n_err++;
            $display("FAIL %s: got flag=%b id=%0d pend=%b ovr=%b busy=%b expected flag=%b id=%0d pend=%b ovr=%b busy=%b at %0t",
                     name, flag_src, id, pend, ovr, busy, f, i, p, o, b, $time);
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit after posedge.
    task automatic step(input logic e, input logic [3:0] q, input logic c);
        @(negedge clk);
        en = e; req = q; clr_ovr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; req = '0; clr_ovr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Step with en=1 until flag_src is seen; n = steps taken (bounded).
    task automatic wait_flag(input string name, output int n);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            step(1'b1, 4'b0000, 1'b0);
            n++;
            if (flag_src) break;
        end
        if (!flag_src) begin
            n_err++;
            $display("FAIL %s: no flag_src within 40 cycles, expected a pulse", name);
        end
    endtask

    initial begin
        int n;
        int flags;
        logic [3:0] p;

        rst = 1'b1; en = 1'b0; req = '0; clr_ovr = 1'b0;

        // ---- Table: single-event latency, then 4-way burst spacing ----
        add(1, 1, 4'b0000, 0,  0, 0, 4'b0000, 4'b0000, 0);  // in reset
        add(0, 1, 4'b0000, 0,  0, 0, 4'b0000, 4'b0000, 0);
        add(0, 1, 4'b0001, 0,  0, 0, 4'b0001, 4'b0000, 1);  // t+1: pend[0]
        add(0, 1, 4'b0000, 0,  1, 0, 4'b0000, 4'b0000, 1);  // t+2: pulse id0
        for (int j = 1; j < GAP - 1; j++)
            add(0, 1, 4'b0000, 0,  0, 0, 4'b0000, 4'b0000, 1);
        add(0, 1, 4'b0000, 0,  0, 0, 4'b0000, 4'b0000, 0);  // idle again
        add(0, 1, 4'b0000, 0,  0, 0, 4'b0000, 4'b0000, 0);
        add(1, 1, 4'b0000, 0,  0, 0, 4'b0000, 4'b0000, 0);  // fresh reset
        add(0, 1, 4'b1111, 0,  0, 0, 4'b1111, 4'b0000, 1);
        for (int k = 0; k < 4; k++) begin
            p = 4'b1111;
            p = p << (k + 1);
            add(0, 1, 4'b0000, 0,  1, 2'(k), p, 4'b0000, 1);
            for (int j = 1; j < GAP - 1; j++)
                add(0, 1, 4'b0000, 0,  0, 2'(k), p, 4'b0000, 1);
            add(0, 1, 4'b0000, 0,  0, 2'(k), p, 4'b0000, (p != 4'b0000));
        end
        add(0, 1, 4'b0000, 0,  0, 3, 4'b0000, 4'b0000, 0);

        for (int v = 0; v < tbl.size(); v++) begin
            @(negedge clk);
            rst = tbl[v].rst; en = tbl[v].en; req = tbl[v].req; clr_ovr = tbl[v].clr;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", v), tbl[v].e_flag, tbl[v].e_id,
                    tbl[v].e_pend, tbl[v].e_ovr, tbl[v].e_busy);
        end

        // ---- Round-robin: launch 1, then req 0 and 3 together in HOLD ----
        do_reset();
        step(1'b1, 4'b0010, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        chk_all("rr_first", 1'b1, 2'd1, 4'b0000, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b1001, 1'b0);
        chk("rr_pend", int'(pend), 9);
        wait_flag("rr_second", n);
        chk("rr_second_id", int'(id), 3);
        wait_flag("rr_third", n);
        chk("rr_third_id", int'(id), 0);
        chk("rr_third_gap", n, GAP);

        // ---- Overrun with en low, single merged launch ----
        do_reset();
        step(1'b0, 4'b0100, 1'b0);
        chk_all("ovr_first", 1'b0, 2'd0, 4'b0100, 4'b0000, 1'b1);
        step(1'b0, 4'b0100, 1'b0);
        chk_all("ovr_set", 1'b0, 2'd0, 4'b0100, 4'b0100, 1'b1);
        step(1'b0, 4'b0000, 1'b0);
        chk("ovr_no_launch_en0", int'(flag_src), 0);
        step(1'b1, 4'b0000, 1'b0);
        chk_all("ovr_launch", 1'b1, 2'd2, 4'b0000, 4'b0100, 1'b1);
        flags = 0;
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 4'b0000, 1'b0);
            if (flag_src) flags++;
        end
        chk("ovr_single_launch", flags, 0);
        step(1'b1, 4'b0000, 1'b1);
        chk("ovr_cleared", int'(ovr), 0);
        step(1'b0, 4'b0100, 1'b0);
        step(1'b0, 4'b0100, 1'b1);
        chk("ovr_beats_clr", int'(ovr), 4);
        step(1'b0, 4'b0000, 1'b0);
        chk("ovr_sticky", int'(ovr), 4);

        // ---- Same-edge re-request of the granted requester ----
        do_reset();
        step(1'b1, 4'b0010, 1'b0);
        step(1'b1, 4'b0010, 1'b0);
        chk_all("same_edge", 1'b1, 2'd1, 4'b0010, 4'b0000, 1'b1);
        wait_flag("same_edge_second", n);
        chk("same_edge_gap", n, GAP);
        chk("same_edge_id", int'(id), 1);
        chk("same_edge_ovr", int'(ovr), 0);

        // ---- Async reset during HOLD with pending work ----
        do_reset();
        step(1'b1, 4'b0001, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0110, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        chk("hold_pend", int'(pend), 6);
        @(negedge clk);
        req = '0;
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        flags = 0;
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 4'b0000, 1'b0);
            if (flag_src || pend != 4'b0000) flags++;
        end
        chk("post_rst_quiet", flags, 0);
        step(1'b1, 4'b0100, 1'b0);
        wait_flag("post_rst_new", n);
        chk("post_rst_new_id", int'(id), 2);
        chk("post_rst_latency", n, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/xd_event_scheduler.md
Name: xd_event_scheduler

Overview:
- Source-domain controller that shares one toggle-based pulse-crossing channel among N_REQ event requesters.
- Latches single-cycle event requests and grants them round-robin.
- Each grant emits one flag_src pulse with a stable requester ID for the crossing logic.
- Enforces a minimum launch spacing so the destination synchroniser never merges or loses toggles and always samples a settled ID.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ID_W, 2, width of the ID bus; must satisfy 2**ID_W >= N_REQ.
- GAP, 8, minimum clk cycles between consecutive flag_src pulses (2..255). Sized by the integrator to cover destination sync latency × clock ratio.

Ports:
- clk  input  1  source-domain clock
- rst  input  1  asynchronous active-high reset
- en  input  1  launch enable; requests still latch when low
- req  input  N_REQ  per-requester single-cycle event pulses
- clr_ovr  input  1  clears all overrun bits
- flag_src  output  1  single-cycle launch pulse to the crossing channel
- id  output  ID_W  index of the last launched requester, held between launches
- pend  output  N_REQ  latched-but-unsent requests
- ovr  output  N_REQ  sticky overrun flags
- busy  output  1  high if any pend bit is set or state != IDLE

Behaviour:
- Reset values (asynchronous, take effect immediately):
  - flag_src=0, id=0, pend=0, ovr=0, state=IDLE, gap counter=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has top priority after reset.
  - Reset mid-HOLD or mid-pulse discards all pending events; no flag_src pulse is emitted after reset release until a new req arrives.
- All outputs are registered.
- pend[i] is set at the edge where req[i]=1.
  - Cleared at the edge where requester i is granted.
  - If req[i]=1 on the same edge as grant of i, pend[i] stays 1 (new event) and ovr[i] is not set.
- ovr[i] is set at the edge where req[i]=1 while pend[i]=1 and i is not granted on that edge. The event is merged (one launch).
  - clr_ovr clears all ovr bits.
  - If clr_ovr and a new overrun occur on the same edge, the overrun wins (bit stays set).
- State machine:
  - IDLE: if en=1 and pend!=0, grant the first set pend bit searching from (last+1) mod N_REQ upward with wrap. At that edge: flag_src<=1, id<=grant, last<=grant, pend[grant]<=0 (subject to the same-edge rule), counter<=GAP-1, go to LAUNCH. Otherwise stay.
  - LAUNCH (1 cycle, flag_src high): flag_src<=0, decrement counter, go to HOLD.
  - HOLD: decrement counter each cycle; at the edge where counter reaches 0, go to IDLE.
  - Net result: a pulse in cycle k allows the next pulse no earlier than cycle k+GAP.
- Latency: req[i] high in cycle t with the block idle, en=1 and no other pending → pend[i]=1 in t+1, flag_src=1 and id=i in t+2.
- id changes only on launch edges, so it is stable for at least GAP cycles after each pulse.
- en low in LAUNCH or HOLD does not abort the holdoff; it only blocks the next grant in IDLE.
- Requests with index >= N_REQ do not exist; id never takes values >= N_REQ.

Test Plan:
- Reset, then req=4'b0001 for one cycle at t=10 → pend[0]=1 at t=11; flag_src=1, id=0 at t=12 only; pend=0, busy=0 from t=12+GAP.
- req=4'b1111 in one cycle, GAP=8 → four pulses at cycles k, k+8, k+16, k+24 with ids 0,1,2,3; no pulse closer than 8 cycles.
- Round-robin check:
  - Launch id=1.
  - Then assert req[0] and req[3] together during HOLD.
  - Next launches are id=3 then id=0.
- Overrun:
  - req[2] at t, again at t+1 while en=0 → ovr[2]=1, a single launch after en=1.
  - clr_ovr pulse → ovr=0.
  - Simultaneous clr_ovr and a new overrun → ovr[2] stays 1.
- Same-edge case: req[1] asserted on the grant edge of requester 1 → pend[1] remains 1, ovr[1]=0, a second id=1 pulse exactly GAP cycles after the first.
- Assert rst asynchronously during HOLD with pend=4'b0110 → all outputs 0 immediately; no flag_src after release until a new req.
